// File: rtl/write_back_stage_pkg.sv
// Shared write-back constants: source-select codes used by decode, control and write-back.
package write_back_stage_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_IDX_W    = 5;

    // Write-back source select codes (WB_SEL_ENUM).
    typedef enum logic [1:0] {
        ALU_OUT = 2'd0,
        IMM_DAT = 2'd1,
        MEM_DAT = 2'd2,
        PC_NEXT = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/write_back_stage_mux4.sv
// Generic Width-bit 4:1 mux, reusable across the datapath.
module write_back_stage_mux4
    import write_back_stage_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [Width-1:0] in0_i,
    input  logic [Width-1:0] in1_i,
    input  logic [Width-1:0] in2_i,
    input  logic [Width-1:0] in3_i,
    output logic [Width-1:0] out_o
);

    // Select one of four inputs; every code is defined so no default path exists.
    always_comb begin
        out_o = in0_i;
        unique case (wb_sel_e'(sel_i))
            ALU_OUT: out_o = in0_i;
            IMM_DAT: out_o = in1_i;
            MEM_DAT: out_o = in2_i;
            PC_NEXT: out_o = in3_i;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Final RV32 pipeline stage: picks the register-file write value and forwards rd / write enable.
// Purely combinational; clk is present only for pipeline uniformity.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           wb_sel,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      immediate,
    input  logic [XLEN-1:0]      mem_data,
    input  logic [XLEN-1:0]      pc_next,
    output logic [XLEN-1:0]      write_data,
    input  logic [REG_IDX_W-1:0] rd_in,
    output logic [REG_IDX_W-1:0] rd_out,
    input  logic                 reg_we_in,
    output logic                 reg_we_out
);

    // No state here, so the clock is intentionally left unconsumed.
    logic unused_clk;
    assign unused_clk = clk;

    write_back_stage_mux4 #(
        .Width (XLEN)
    ) u_mux4 (
        .sel_i (wb_sel),
        .in0_i (alu_result),
        .in1_i (immediate),
        .in2_i (mem_data),
        .in3_i (pc_next),
        .out_o (write_data)
    );

    // rd passes straight through (x0 filtering is the register file's job);
    // the write enable is killed asynchronously while reset is held.
    always_comb begin
        rd_out     = rd_in;
        reg_we_out = reg_we_in & rst_n;
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed cases then a randomized sweep.
module tb_write_back_stage;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic [1:0]      wb_sel;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] immediate;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] write_data;
    logic [4:0]      rd_in;
    logic [4:0]      rd_out;
    logic            reg_we_in;
    logic            reg_we_out;

    int vectors;
    int miscompares;

    write_back_stage #(
        .XLEN (XLEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_sel     (wb_sel),
        .alu_result (alu_result),
        .immediate  (immediate),
        .mem_data   (mem_data),
        .pc_next    (pc_next),
        .write_data (write_data),
        .rd_in      (rd_in),
        .rd_out     (rd_out),
        .reg_we_in  (reg_we_in),
        .reg_we_out (reg_we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] i,
                         input logic [31:0] m, input logic [31:0] p, input logic [4:0] rd,
                         input logic we, input logic rst);
        wb_sel     = sel;
        alu_result = a;
        immediate  = i;
        mem_data   = m;
        pc_next    = p;
        rd_in      = rd;
        reg_we_in  = we;
        rst_n      = rst;
    endtask

    // Reference: write-back value per the source-select table, expressed as a lookup.
    function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [31:0] a,
                                             input logic [31:0] i, input logic [31:0] m,
                                             input logic [31:0] p);
        logic [31:0] srcs [4];
        srcs[0] = a;
        srcs[1] = i;
        srcs[2] = m;
        srcs[3] = p;
        return srcs[sel];
    endfunction

    initial begin
        logic [31:0] a, i, m, p;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we, rst;

        vectors     = 0;
        miscompares = 0;

        // Reset held with write enable requested: enable must be suppressed.
        drive(2'd0, 32'd1, 32'd2, 32'd3, 32'd4, 5'd5, 1'b1, 1'b0);
        #1;
        check("reset_we", {31'd0, reg_we_out}, 32'd0);
        check("reset_data", write_data, 32'd1);
        check("reset_rd", {27'd0, rd_out}, 32'd5);

        @(negedge clk);
        drive(2'd0, 32'd1, 32'd2, 32'd3, 32'd4, 5'd5, 1'b1, 1'b1);
        #1;
        check("alu_data", write_data, 32'd1);
        check("alu_rd", {27'd0, rd_out}, 32'd5);
        check("alu_we", {31'd0, reg_we_out}, 32'd1);

        @(negedge clk);
        drive(2'd1, 32'd1, 32'd2, 32'd3, 32'd4, 5'd0, 1'b1, 1'b1);
        #1;
        check("imm_data", write_data, 32'd2);
        check("imm_rd0", {27'd0, rd_out}, 32'd0);
        check("imm_we_x0", {31'd0, reg_we_out}, 32'd1);

        @(negedge clk);
        drive(2'd2, 32'd1, 32'd2, 32'd3, 32'd4, 5'd1, 1'b0, 1'b1);
        #1;
        check("mem_data", write_data, 32'd3);
        check("mem_rd", {27'd0, rd_out}, 32'd1);
        check("mem_we", {31'd0, reg_we_out}, 32'd0);

        @(negedge clk);
        drive(2'd3, 32'd1, 32'd2, 32'd3, 32'd4, 5'd0, 1'b0, 1'b1);
        #1;
        check("pc_data", write_data, 32'd4);
        check("pc_rd", {27'd0, rd_out}, 32'd0);
        check("pc_we", {31'd0, reg_we_out}, 32'd0);

        // Mid-cycle asynchronous reset: enable drops, data still flows.
        @(negedge clk);
        drive(2'd0, 32'hDEADBEEF, 32'd2, 32'd3, 32'd4, 5'd7, 1'b1, 1'b1);
        #1;
        check("pre_rst_we", {31'd0, reg_we_out}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_we", {31'd0, reg_we_out}, 32'd0);
        check("rst_data", write_data, 32'hDEADBEEF);
        check("rst_rd", {27'd0, rd_out}, 32'd7);
        rst_n = 1'b1;
        #1;
        check("release_we", {31'd0, reg_we_out}, 32'd1);

        // Randomized sweep: wb_sel walks 0..3 while data, rd, we and reset vary.
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            sel = 2'(n % 4);
            a   = $urandom;
            i   = $urandom;
            m   = $urandom;
            p   = $urandom;
            rd  = 5'($urandom_range(0, 31));
            we  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 7) != 0);
            drive(sel, a, i, m, p, rd, we, rst);
            #1;
            check("rand_data", write_data, ref_data(sel, a, i, m, p));
            check("rand_rd", {27'd0, rd_out}, {27'd0, rd});
            check("rand_we", {31'd0, reg_we_out}, {31'd0, we && rst});
            // Change select and data together mid-cycle; output follows the new choice.
            sel = 2'($urandom_range(0, 3));
            a   = $urandom;
            p   = $urandom;
            drive(sel, a, i, m, p, rd, we, rst);
            #1;
            check("rand_resel", write_data, ref_data(sel, a, i, m, p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final pipeline stage of the RV32 core. It selects the register-file write-back value from four sources: ALU result, immediate, memory load data, or PC+4. It passes the destination register index and write enable through to the register file. The datapath is purely combinational; clock and reset exist for pipeline uniformity and for reset gating of the write enable.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  input  1  core clock; single clock domain.
- rst_n  input  1  reset, asynchronous and active-low.
- wb_sel  input  2  write-back source select (WB_SEL_ENUM encoding).
- alu_result  input  XLEN  ALU output.
- immediate  input  XLEN  decoded immediate (LUI path).
- mem_data  input  XLEN  load data, already aligned and extended.
- pc_next  input  XLEN  PC+4 (JAL/JALR link value).
- write_data  output  XLEN  value to write to rd.
- rd_in  input  5  destination register index.
- rd_out  output  5  destination index to the register file.
- reg_we_in  input  1  register write enable from decode.
- reg_we_out  output  1  write enable to the register file.

## Operation
- write_data is selected by wb_sel:
  - ALU_OUT = 2'd0 → alu_result
  - IMM_DAT = 2'd1 → immediate
  - MEM_DAT = 2'd2 → mem_data
  - PC_NEXT = 2'd3 → pc_next
- All four codes are defined, so there is no default or illegal case.
- rd_out = rd_in unconditionally, including rd_in = 0. x0 suppression belongs to the register file, not this block.
- reg_we_out = reg_we_in & rst_n. The write enable is forced to 0 while reset is asserted and passes through unmodified otherwise, including when rd_in = 0.
- write_data and rd_out are not gated by reset.
- No internal state and no arithmetic. No width conversion: all data inputs are XLEN.

## Timing
- Zero-cycle latency: all outputs are combinational functions of the current inputs and settle within the same cycle.
- clk is not used by the datapath. No registers in this block.
- Reset assertion drops reg_we_out to 0 immediately (asynchronous, combinational). Deassertion restores pass-through with no cycle delay.
- Simultaneous changes of wb_sel and data inputs resolve to the newly selected input after settling. There are no glitch guarantees; the register file samples on the clock edge.
- No handshake; the block is always ready.

## Structure
- WB_SEL_ENUM is a shared constants module/package holding the 2-bit codes ALU_OUT, IMM_DAT, MEM_DAT and PC_NEXT. Decode, control and this stage all reference it; no literal codes appear in RTL.
- A single flat module. The natural sub-module is an XLEN-wide 4:1 mux (mux4), reusable elsewhere in the datapath.

## Test plan
- Inputs alu=1, imm=2, mem=3, pc_next=4, rd_in=5, we_in=1, wb_sel=ALU_OUT, rst_n=1 → write_data=1, rd_out=5, reg_we_out=1.
- wb_sel=IMM_DAT, rd_in=0, we_in=1 → write_data=2, rd_out=0, reg_we_out=1 (no x0 suppression).
- wb_sel=MEM_DAT, rd_in=1, we_in=0 → write_data=3, rd_out=1, reg_we_out=0.
- wb_sel=PC_NEXT, rd_in=0, we_in=0 → write_data=4, rd_out=0, reg_we_out=0.
- rst_n=0 with we_in=1, wb_sel=ALU_OUT, alu=32'hDEADBEEF → reg_we_out=0, write_data=32'hDEADBEEF. Release rst_n → reg_we_out=1 within 1 ns.
- Sweep wb_sel 0..3 each cycle with random data; check write_data against the reference mux 1 ns after every change.
